// File: rtl/rptr_empty_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rptr_empty_sync
//  Description : Read-side pointer and empty-flag logic for an asynchronous
//                FIFO. Double-flop synchronizes the Gray write pointer into
//                the read clock domain, keeps the binary/Gray read pointers,
//                drives the memory read address and produces the empty,
//                almost-empty and sticky underflow flags.
//                Optional macro AFIFO_RLEVEL_EN adds the registered rlevel
//                occupancy output.
//  Revision    : 1.0 - initial release
// ============================================================================
module rptr_empty_sync #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH-1:0] wptr,
  output logic [ADDR_WIDTH-1:0] rptr,
  output logic [ADDR_WIDTH-2:0] raddr,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic                  rd_underflow
`ifdef AFIFO_RLEVEL_EN
  ,
  output logic [ADDR_WIDTH-1:0] rlevel
`endif
);

  // Threshold resized to pointer width so the level compare is width-clean.
  localparam logic [ADDR_WIDTH-1:0] c_AE_THRESH = ADDR_WIDTH'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] c_ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ZERO      = '0;

  // Gray-to-binary conversion: each binary bit is the XOR of all Gray bits
  // at or above it.
  function automatic logic [ADDR_WIDTH-1:0] gray2bin(input logic [ADDR_WIDTH-1:0] g);
    logic [ADDR_WIDTH-1:0] b;
    b[ADDR_WIDTH-1] = g[ADDR_WIDTH-1];
    for (int i = ADDR_WIDTH-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_rq1_wptr;
  logic [ADDR_WIDTH-1:0] r_rq2_wptr;
  logic [ADDR_WIDTH-1:0] r_rbin;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic                  r_rempty;
  logic                  r_ralmost_empty;
  logic                  r_rd_underflow;

  // --------------------------------------------------------------------------
  // Combinational next-state terms
  // --------------------------------------------------------------------------
  logic                  w_rvalid;
  logic                  w_underflow_evt;
  logic [ADDR_WIDTH-1:0] w_rbinnext;
  logic [ADDR_WIDTH-1:0] w_rgraynext;
  logic [ADDR_WIDTH-1:0] w_wbin_s;
  logic [ADDR_WIDTH-1:0] w_lvl;
  logic                  w_rempty_next;
  logic                  w_ralmost_empty_next;

  // A pop only happens when the registered empty flag allows it; a request
  // against an empty FIFO is recorded as underflow and leaves pointers alone.
  assign w_rvalid        = rinc & ~r_rempty;
  assign w_underflow_evt = rinc &  r_rempty;

  // Next pointers; wrap at 2^ADDR_WIDTH comes for free from the adder width.
  assign w_rbinnext  = r_rbin + (w_rvalid ? c_ONE : c_ZERO);
  assign w_rgraynext = (w_rbinnext >> 1) ^ w_rbinnext;

  // Occupancy as seen through the synchronizer, measured against the
  // post-pop pointer so a pop and a new write pointer resolve together.
  assign w_wbin_s = gray2bin(r_rq2_wptr);
  assign w_lvl    = w_wbin_s - w_rbinnext;

  // Full Gray equality (including the wrap bit) is the empty condition.
  assign w_rempty_next        = (w_rgraynext == r_rq2_wptr);
  assign w_ralmost_empty_next = (w_lvl <= c_AE_THRESH);

  // Two-flop synchronizer: the only place wptr is sampled.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rq1_wptr <= '0;
      r_rq2_wptr <= '0;
    end else begin
      r_rq1_wptr <= wptr;
      r_rq2_wptr <= r_rq1_wptr;
    end
  end

  // Binary and Gray read pointers advance together on each accepted pop.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rbin <= '0;
      r_rptr <= '0;
    end else begin
      r_rbin <= w_rbinnext;
      r_rptr <= w_rgraynext;
    end
  end

  // Empty and almost-empty flags; both come up asserted out of reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rempty        <= 1'b1;
      r_ralmost_empty <= 1'b1;
    end else begin
      r_rempty        <= w_rempty_next;
      r_ralmost_empty <= w_ralmost_empty_next;
    end
  end

  // Sticky underflow: once set it stays set until reset.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rd_underflow <= 1'b0;
    end else if (w_underflow_evt) begin
      r_rd_underflow <= 1'b1;
    end
  end

`ifdef AFIFO_RLEVEL_EN
  logic [ADDR_WIDTH-1:0] r_rlevel;

  // Registered occupancy, aligned in time with the almost-empty flag.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_rlevel <= '0;
    end else begin
      r_rlevel <= w_lvl;
    end
  end

  assign rlevel = r_rlevel;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rptr          = r_rptr;
  assign raddr         = r_rbin[ADDR_WIDTH-2:0];
  assign rempty        = r_rempty;
  assign ralmost_empty = r_ralmost_empty;
  assign rd_underflow  = r_rd_underflow;

endmodule
`default_nettype wire

// File: doc/rptr_empty_sync.md
Name: rptr_empty_sync

Overview:
- Read-side pointer and empty-flag block for the asynchronous FIFO.
- Double-flop synchronizes the write-domain Gray write pointer into the read clock domain.
- Maintains the binary and Gray read pointers, and drives the memory read address.
- Generates the empty, almost-empty and underflow flags. It is the read-domain counterpart of the write-side pointer/full logic; its Gray rptr output feeds the read-to-write synchronizer.

Parameters:
- ADDR_WIDTH, 4, pointer width including the wrap bit. Memory address is ADDR_WIDTH-1 bits, so depth = 2^(ADDR_WIDTH-1) = 8 at default.
- AE_THRESH, 2, almost-empty threshold in entries; ralmost_empty is asserted while the synchronized level is <= AE_THRESH. Legal range 0 .. 2^(ADDR_WIDTH-1)-1.

Ports:
- rclk  input  1  read-domain clock; all logic is on the rising edge.
- rrst  input  1  synchronous, active-high reset, sampled on rising rclk.
- rinc  input  1  read request; one entry is popped per cycle when the FIFO is not empty.
- wptr  input  ADDR_WIDTH  Gray-coded write pointer, asynchronous to rclk.
- rptr  output  ADDR_WIDTH  registered Gray read pointer, sent to the write domain.
- raddr  output  ADDR_WIDTH-1  read address into the dual-port memory.
- rempty  output  1  registered empty flag.
- ralmost_empty  output  1  registered almost-empty flag.
- rd_underflow  output  1  sticky flag: a read was attempted while empty.
- rlevel  output  ADDR_WIDTH  synchronized occupancy. Present only with AFIFO_RLEVEL_EN.

Behaviour:
- Reset (rrst=1 at a rising edge):
  - rq1_wptr, rq2_wptr, rbin and rptr are cleared to 0.
  - rempty=1, ralmost_empty=1, rd_underflow=0, rlevel=0.
  - raddr is therefore 0.
  - Reset overrides rinc in the same cycle. A mid-operation reset discards all read state in one cycle.
- Synchronizer:
  - {rq2_wptr, rq1_wptr} <= {rq1_wptr, wptr} every rclk.
  - rq2_wptr is the only consumer of wptr; no other logic samples wptr directly.
- Pointer update:
  - rvalid = rinc & ~rempty.
  - rbinnext = rbin + rvalid, modulo 2^ADDR_WIDTH.
  - rgraynext = (rbinnext >> 1) ^ rbinnext.
  - Registered: rbin <= rbinnext; rptr <= rgraynext.
- raddr = rbin[ADDR_WIDTH-2:0], combinational from the register. Read data for the current raddr is valid in the same cycle rinc is asserted.
- Empty:
  - rempty <= (rgraynext == rq2_wptr).
  - The last pop (rvalid with one entry left) asserts rempty on the next edge, with no bubble.
- Latency:
  - wptr change to rempty deassert = 3 rclk edges (2 synchronizer stages + flag register).
  - rptr updates 1 edge after rvalid.
- Level:
  - wbin_s = Gray-to-binary of rq2_wptr.
  - lvl = (wbin_s - rbinnext) mod 2^ADDR_WIDTH, range 0 .. 2^(ADDR_WIDTH-1).
  - Registered: ralmost_empty <= (lvl <= AE_THRESH).
- Wrap-around:
  - Pointers wrap naturally at 2^ADDR_WIDTH.
  - The wrap bit distinguishes a lap, so rempty depends only on full Gray equality.
- Underflow:
  - rinc=1 while rempty=1 leaves rbin and rptr unchanged and sets rd_underflow on the next edge.
  - rd_underflow holds until rrst.
- Simultaneous events:
  - A pop together with a new synchronized write pointer is evaluated against the new rq2_wptr in the same edge.
  - rempty is pessimistic: it may lag a write by up to 3 cycles but never deasserts early.

Optional Feature:
- AFIFO_RLEVEL_EN defined:
  - The rlevel port exists, registered with rlevel <= lvl, reset value 0.
  - Same timing as ralmost_empty.
- Not defined:
  - The rlevel port and its register are absent.
  - lvl is still computed internally for ralmost_empty.
  - All other behaviour is identical.

Test Plan:
- Reset: drive wptr=4'b0110, hold rrst for 2 cycles -> rempty=1, ralmost_empty=1, rptr=0, raddr=0, rd_underflow=0, rlevel=0.
- Fill visibility: from reset, step wptr Gray 0->1->3->2 (3 writes), holding each for 1 cycle with rinc=0 -> rempty falls 3 edges after the first change. rlevel settles at 3; ralmost_empty is 1 at level 2 or less and 0 once the level reaches 3.
- Drain: with level 3, hold rinc=1 for 4 cycles -> raddr steps 0,1,2 and rptr steps 1,3,2. rempty=1 after the 3rd pop; the 4th rinc sets rd_underflow=1 and rbin stays 3.
- Wrap-around: run 20 write/read pairs with the write side leading by 1 -> rbin wraps 15->0, rptr Gray wraps 4'b1000->4'b0000. rempty toggles correctly and raddr wraps 7->0.
- Full lap: wptr Gray for binary 8 (4'b1100) against rbin=0 -> after sync, rempty=0, lvl=8, ralmost_empty=0.
- Mid-operation reset: at level 5 with rinc=1, assert rrst for 1 cycle -> all outputs return to reset values next edge. rd_underflow is cleared; the synchronizer refills from the live wptr 2 cycles later.
